// File: rtl/capture_ctrl.sv
// Capture controller: arms on trig_en, fills pre-trigger history, waits for a
// pin edge / force / auto-timeout, takes trig_pos post-trigger writes, then holds the record.
module capture_ctrl #(
    parameter int NUM_TRIG = 3,
    parameter int AW       = 9,
    parameter int AUTO_TO  = 1023,
    parameter int TSW      = $clog2(NUM_TRIG)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NUM_TRIG-1:0] trig,
    input  logic [TSW-1:0]      trig_src,
    input  logic                trig_edge,
    input  logic                auto_mode,
    input  logic                force_trig,
    input  logic                trig_en,
    input  logic [AW-1:0]       trig_pos,
    input  logic [3:0]          decimator,
    input  logic                smpl_strb,
    input  logic                clr_cap_done,
    output logic                we,
    output logic [AW-1:0]       addr_ptr,
    output logic [AW-1:0]       trig_addr,
    output logic                capture_done,
    output logic                armed,
    output logic                auto_trigd
);
    localparam int ACW = $clog2(AUTO_TO + 1);

    typedef enum logic [2:0] {IDLE, FILL, ARMED, POST, DONE} state_t;

    state_t              state;
    logic [NUM_TRIG-1:0] trig_s1, trig_s2, trig_s3;
    logic [15:0]         dcnt, dlim;
    logic [AW-1:0]       fill_cnt, post_cnt, fill_tgt;
    logic [ACW-1:0]      arm_cnt;
    logic                pend, pend_auto;
    logic                slot, sel_now, sel_prev, pin_edge, auto_hit, qual;
    logic                fill_last, post_last;

    assign dlim      = 16'((17'd1 << decimator) - 17'd1);
    assign slot      = smpl_strb && (dcnt == '0);
    assign we        = slot && (state == FILL || state == ARMED || state == POST);
    // ~trig_pos == DEPTH-1-trig_pos in AW bits
    assign fill_tgt  = ~trig_pos;
    assign fill_last = (fill_tgt == '0) || (we && (fill_cnt + AW'(1) == fill_tgt));
    assign post_last = we && (post_cnt + AW'(1) == trig_pos);

    // Out-of-range trig_src leaves both taps low, so no edge can ever be seen.
    always_comb begin
        sel_now  = 1'b0;
        sel_prev = 1'b0;
        for (int unsigned i = 0; i < NUM_TRIG; i++) begin
            if (trig_src == TSW'(i)) begin
                sel_now  = trig_s2[i];
                sel_prev = trig_s3[i];
            end
        end
    end

    assign pin_edge = (state == ARMED) &&
                      (trig_edge ? (sel_now && !sel_prev) : (!sel_now && sel_prev));
    assign auto_hit = auto_mode && (state == ARMED) && we && (arm_cnt == ACW'(AUTO_TO - 1));
    assign qual     = pin_edge || (force_trig && (state == ARMED)) || auto_hit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            trig_s1      <= '0;
            trig_s2      <= '0;
            trig_s3      <= '0;
            dcnt         <= '0;
            fill_cnt     <= '0;
            post_cnt     <= '0;
            arm_cnt      <= '0;
            pend         <= 1'b0;
            pend_auto    <= 1'b0;
            addr_ptr     <= '0;
            trig_addr    <= '0;
            capture_done <= 1'b0;
            armed        <= 1'b0;
            auto_trigd   <= 1'b0;
        end else begin
            trig_s1 <= trig;
            trig_s2 <= trig_s1;
            trig_s3 <= trig_s2;

            if (state == IDLE)
                dcnt <= '0;
            else if (smpl_strb)
                dcnt <= (dcnt == dlim) ? '0 : dcnt + 16'd1;

            if (we)
                addr_ptr <= addr_ptr + AW'(1);

            case (state)
                IDLE: begin
                    fill_cnt  <= '0;
                    post_cnt  <= '0;
                    arm_cnt   <= '0;
                    pend      <= 1'b0;
                    pend_auto <= 1'b0;
                    if (trig_en)
                        state <= FILL;
                end
                FILL: begin
                    if (!trig_en) begin
                        state <= IDLE;
                    end else begin
                        if (we)
                            fill_cnt <= fill_cnt + AW'(1);
                        if (fill_last) begin
                            state <= ARMED;
                            armed <= 1'b1;
                        end
                    end
                end
                ARMED: begin
                    if (!trig_en) begin
                        state <= IDLE;
                        armed <= 1'b0;
                    end else begin
                        if (we && arm_cnt != ACW'(AUTO_TO))
                            arm_cnt <= arm_cnt + ACW'(1);
                        if (pend && we) begin
                            trig_addr  <= addr_ptr;
                            auto_trigd <= pend_auto;
                            armed      <= 1'b0;
                            if (trig_pos == '0) begin
                                state        <= DONE;
                                capture_done <= 1'b1;
                            end else begin
                                state <= POST;
                            end
                        end else if (!pend && qual) begin
                            pend      <= 1'b1;
                            pend_auto <= !pin_edge;
                        end
                    end
                end
                POST: begin
                    if (!trig_en) begin
                        state <= IDLE;
                    end else begin
                        if (we)
                            post_cnt <= post_cnt + AW'(1);
                        if (post_last) begin
                            state        <= DONE;
                            capture_done <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    if (clr_cap_done) begin
                        state        <= IDLE;
                        capture_done <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/capture_ctrl.md
# capture_ctrl

Parametrised capture controller for the scope's digital core: it generalises trigger capture to N trigger sources, power-of-two record depth, selectable edge, auto-trigger and forced trigger. It sits between the AFE trigger pins and the channel RAMs and drives the common RAM write address and write strobe. It hands a finished record (`capture_done`, oldest address, trigger address) to the command/dump logic.

## Interface
- NUM_TRIG, 3, number of raw trigger inputs (>=2)
- AW, 9, RAM address width; record depth DEPTH = 2**AW
- AUTO_TO, 1023, writes allowed in ARMED before auto-trigger fires
- TSW, $clog2(NUM_TRIG), width of trig_src

- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- trig  in  NUM_TRIG  raw asynchronous trigger pins
- trig_src  in  TSW  selects trigger source; values >= NUM_TRIG select none
- trig_edge  in  1  1 = rising, 0 = falling
- auto_mode  in  1  enables auto-trigger timeout
- force_trig  in  1  one-cycle software trigger, honoured only in ARMED
- trig_en  in  1  level; arms capture while high
- trig_pos  in  AW  writes taken after the trigger sample
- decimator  in  4  write one sample every 2**decimator strobes
- smpl_strb  in  1  one-cycle ADC sample strobe
- clr_cap_done  in  1  acknowledges a completed record
- we  out  1  RAM write strobe, one cycle per stored sample
- addr_ptr  out  AW  current write address; after done, the oldest sample
- trig_addr  out  AW  address of the trigger sample
- capture_done  out  1  record complete (level)
- armed  out  1  high in ARMED
- auto_trigd  out  1  last record was triggered by timeout or force

## Operation
- States: IDLE, FILL, ARMED, POST, DONE. Reset forces IDLE and clears all outputs and counters to 0.
- Decimation:
  - A write slot occurs on `smpl_strb` when the decimation counter is 0.
  - The counter increments on each strobe and wraps at 2**decimator - 1.
  - With decimator=0, every strobe is a slot.
  - The counter clears in IDLE.
- Each write slot outside IDLE/DONE asserts `we` for that cycle and, on the next clock, advances `addr_ptr` modulo DEPTH.
- IDLE -> FILL when `trig_en` = 1.
- FILL:
  - Counts writes.
  - -> ARMED once DEPTH-1-trig_pos writes have completed, which guarantees the pre-trigger history.
  - If trig_pos = DEPTH-1, go to ARMED directly.
- ARMED:
  - A qualified trigger sets a pending flag.
  - Qualified trigger sources: selected edge on the synchronised `trig[trig_src]`, `force_trig`, or, if `auto_mode`, the ARMED write count reaching AUTO_TO.
  - The next write slot is the trigger sample. On that slot: `trig_addr` <= `addr_ptr`, `auto_trigd` <= 1 if the trigger was force/timeout (else 0), and the state goes -> POST.
- POST:
  - Takes trig_pos further writes, then -> DONE.
  - If trig_pos = 0, the trigger write goes straight to DONE.
- DONE:
  - `capture_done` = 1 and `we` = 0.
  - `addr_ptr` holds, pointing at the oldest sample.
  - `clr_cap_done` -> IDLE.
- `trig_en` low in FILL/ARMED/POST aborts to IDLE. `capture_done` stays 0, and `addr_ptr` and `trig_addr` hold.
- Trigger synchroniser:
  - Two flops per pin, plus one registered copy for edge detect.
  - Edges are detected only while ARMED; edges in FILL are ignored.
- Multiple qualifiers in one cycle count as one trigger. Pin-edge priority applies for `auto_trigd`.

## Timing
- A pin edge reaches the pending flag 3 clk after the pin changes.
- The trigger sample is the first write slot after the pending flag is set.
- `capture_done` rises on the clk after the final POST write.
- DONE + `clr_cap_done` -> IDLE next clk.
  - If `trig_en` is still high, FILL follows one clk later.
  - `capture_done` drops with the exit from DONE.
- `armed` is registered and equals (state == ARMED).
- A pending trigger plus a coincident write slot in the same cycle: that slot is the trigger sample.
- `trig_src` and `trig_edge` changes take effect on edge detect in the next cycle. They must only change in IDLE.
- Asynchronous reset mid-capture returns to IDLE at once. Every output is 0.

## Test plan
- AW=9, decimator=0, strobe every cycle, trig_pos=100:
  - Expect ARMED after 411 writes.
  - A rising edge on trig[1] (src=1) yields exactly 101 writes from `trig_addr`.
  - Expect `capture_done`, with `addr_ptr` = (`trig_addr`+101) mod 512.
- decimator=3:
  - `we` pulses once per 8 strobes.
  - Write count in FILL = 411 writes over 3288 strobes.
- auto_mode=1, AUTO_TO=1023, no pin edges:
  - Trigger fires on ARMED write 1023 and `auto_trigd` = 1.
  - A repeat run with a pin edge at ARMED write 10 gives `auto_trigd` = 0.
- trig_edge=0, src=2: a rising pulse on trig[2] does not trigger; the falling edge does. Edges during FILL are ignored.
- Abort: drop `trig_en` in POST after 50 writes -> IDLE. `capture_done` stays 0, `we` stops, `addr_ptr` holds.
- Boundaries:
  - trig_pos=0: done on the trigger write.
  - trig_pos=511: ARMED immediately after FILL entry.
  - Address wraps 511->0 during POST.
  - `clr_cap_done` with `trig_en`=1 rearms (IDLE then FILL).
  - `rst_n` low mid-POST zeroes all outputs.
